// File: rtl/ifetch.sv
// Instruction fetch stage: issues one instruction-bus request at a time,
// buffers a response that arrives while decode is stalled, and squashes
// in-flight fetches on a redirect from decode.

package ifetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ,   // request outstanding at req_addr
        HOLD,  // response captured while stalled, bus idle
        DROP   // stale request in flight, its response is discarded
    } state_e;

endpackage

module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [63:0] hold_pc_q, hold_pc_d;
    fetch_data_t data_f_q, data_f_d;

    logic [63:0] target_pc;
    logic [63:0] req_addr_inc;
    logic        unused_pc_bits;

    // Branch targets are forced word-aligned; the low bits are ignored.
    assign target_pc      = {redirect_pc[63:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];
    // Plain 64-bit add wraps modulo 2^64 at the top of the address space.
    assign req_addr_inc   = req_addr_q + 64'd4;

    // Bus request is decoded straight from the state register.
    assign ireq_valid = (state_q != HOLD);
    assign ireq_addr  = req_addr_q;
    assign dataF      = data_f_q;

    // Next-state and datapath decisions; redirect outranks stall and data_ok.
    always_comb begin
        // NOTE: every _d gets a default of its _q first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        data_f_d     = data_f_q;

        if (redirect) begin
            pc_d           = target_pc;
            data_f_d.valid = 1'b0;
            hold_instr_d   = '0;
            hold_pc_d      = '0;
        end

        case (state_q)
            REQ: begin
                if (redirect) begin
                    if (iresp_data_ok) begin
                        req_addr_d = target_pc;
                    end else begin
                        state_d = DROP;
                    end
                end else if (iresp_data_ok) begin
                    pc_d = req_addr_inc;
                    if (stall) begin
                        hold_instr_d = iresp_data;
                        hold_pc_d    = req_addr_q;
                        state_d      = HOLD;
                    end else begin
                        data_f_d   = '{instr: iresp_data, pc: req_addr_q, valid: 1'b1};
                        req_addr_d = req_addr_inc;
                    end
                end else if (!stall) begin
                    data_f_d.valid = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    req_addr_d = target_pc;
                    state_d    = REQ;
                end else if (!stall) begin
                    data_f_d   = '{instr: hold_instr_q, pc: hold_pc_q, valid: 1'b1};
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end

            DROP: begin
                // A redirect here only retargets pc; the stale request stays driven.
                if (!redirect && iresp_data_ok) begin
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end

            default: state_d = REQ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= REQ;
            pc_q         <= PC_RESET;
            req_addr_q   <= PC_RESET;
            // NOTE: the hold buffer is a single entry of flops, not a RAM, so
            // clearing it on reset is cheap and keeps X out of dataF.
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            data_f_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            data_f_q     <= data_f_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: scenario tasks drive the bus and hazard
// inputs, push expected F/D payloads into a scoreboard queue and compare
// when the payload is due.

module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    fetch_data_t sb[$];
    fetch_data_t exp_f;
    fetch_data_t held_f;
    int          n_assert = 0;
    int          n_fail   = 0;

    ifetch #(.PC_RESET(PC_RESET)) dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dataF        (dataF)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 64'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
    endtask

    // Respond to the current request and push the expected payload.
    task automatic respond(input logic [31:0] data, input logic [63:0] addr);
        iresp_data_ok = 1'b1;
        iresp_data    = data;
        sb.push_back('{instr: data, pc: addr, valid: 1'b1});
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        n_assert++;
        if (dataF !== '0) begin
            n_fail++;
            $display("FAIL reset_dataF: got %h expected 0", dataF);
        end
        reset = 1'b1;
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET) begin
            n_fail++;
            $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=%h",
                     ireq_valid, ireq_addr, PC_RESET);
        end
    endtask

    task automatic test_stream();
        logic [63:0] addr;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            addr = PC_RESET + 64'(4 * i);
            n_assert++;
            if (ireq_valid !== 1'b1 || ireq_addr !== addr) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: got valid=%b addr=%h expected valid=1 addr=%h",
                         i, ireq_valid, ireq_addr, addr);
            end
            respond(32'h0000_0013 | (32'(i) << 7), addr);
            tick();
            exp_f = sb.pop_front();
            n_assert++;
            if (dataF !== exp_f) begin
                n_fail++;
                $display("FAIL stream_dataF[%0d]: got %h expected %h", i, dataF, exp_f);
            end
        end
        iresp_data_ok = 1'b0;
        tick();
        n_assert++;
        if (dataF.valid !== 1'b0 || ireq_addr !== PC_RESET + 64'h20) begin
            n_fail++;
            $display("FAIL stream_bubble: got valid=%b addr=%h expected valid=0 addr=%h",
                     dataF.valid, ireq_addr, PC_RESET + 64'h20);
        end
    endtask

    task automatic test_stall();
        do_reset();
        respond(32'h1111_0013, PC_RESET);
        tick();
        held_f = sb.pop_front();
        // Stall with no response: payload held, request unchanged.
        iresp_data_ok = 1'b0;
        stall         = 1'b1;
        tick();
        n_assert++;
        if (dataF !== held_f || ireq_addr !== PC_RESET + 64'h4) begin
            n_fail++;
            $display("FAIL stall_noresp: got dataF=%h addr=%h expected dataF=%h addr=%h",
                     dataF, ireq_addr, held_f, PC_RESET + 64'h4);
        end
        // Response for 80000004 during a 3-cycle stall.
        respond(32'h2222_0013, PC_RESET + 64'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            iresp_data_ok = 1'b0;
            n_assert++;
            if (ireq_valid !== 1'b0 || dataF !== held_f) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b dataF=%h expected valid=0 dataF=%h",
                         i, ireq_valid, dataF, held_f);
            end
        end
        stall = 1'b0;
        tick();
        exp_f = sb.pop_front();
        n_assert++;
        if (dataF !== exp_f) begin
            n_fail++;
            $display("FAIL stall_release_dataF: got %h expected %h", dataF, exp_f);
        end
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET + 64'h8) begin
            n_fail++;
            $display("FAIL stall_release_req: got valid=%b addr=%h expected valid=1 addr=%h",
                     ireq_valid, ireq_addr, PC_RESET + 64'h8);
        end
        tick();
        n_assert++;
        if (dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bubble: got valid=%b expected 0", dataF.valid);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            respond(32'h3300_0013 + 32'(i), PC_RESET + 64'(4 * i));
            tick();
            exp_f = sb.pop_front();
            n_assert++;
            if (dataF !== exp_f) begin
                n_fail++;
                $display("FAIL drop_pre[%0d]: got %h expected %h", i, dataF, exp_f);
            end
        end
        iresp_data_ok = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 64'h0000_0000_8000_0103;
        for (int i = 0; i < 2; i++) begin
            tick();
            redirect = 1'b0;
            n_assert++;
            if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010 || dataF.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_wait[%0d]: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                         i, ireq_valid, ireq_addr, dataF.valid, 64'h8000_0010);
            end
        end
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        tick();
        n_assert++;
        if (ireq_addr !== 64'h8000_0100 || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_done: got addr=%h fvalid=%b expected addr=%h fvalid=0",
                     ireq_addr, dataF.valid, 64'h8000_0100);
        end
        respond(32'h4444_0013, 64'h8000_0100);
        tick();
        iresp_data_ok = 1'b0;
        exp_f = sb.pop_front();
        n_assert++;
        if (dataF !== exp_f || ireq_addr !== 64'h8000_0104) begin
            n_fail++;
            $display("FAIL drop_after: got dataF=%h addr=%h expected dataF=%h addr=%h",
                     dataF, ireq_addr, exp_f, 64'h8000_0104);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Redirect together with a response, no stall.
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hBAD0_0001;
        redirect      = 1'b1;
        redirect_pc   = 64'h8000_0200;
        tick();
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200 || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_redir_ok: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                     ireq_valid, ireq_addr, dataF.valid, 64'h8000_0200);
        end
        // Redirect together with a response while stalled.
        iresp_data  = 32'hBAD0_0002;
        redirect_pc = 64'h8000_0302;
        stall       = 1'b1;
        tick();
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300 || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_redir_stall: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                     ireq_valid, ireq_addr, dataF.valid, 64'h8000_0300);
        end
        // Enter HOLD, then redirect out of it while still stalled.
        redirect = 1'b0;
        respond(32'hBAD0_0003, 64'h8000_0300);
        tick();
        n_assert++;
        if (ireq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: got valid=%b expected 0", ireq_valid);
        end
        sb.delete();
        iresp_data_ok = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 64'h8000_0400;
        tick();
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0400 || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold_redir: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                     ireq_valid, ireq_addr, dataF.valid, 64'h8000_0400);
        end
        redirect = 1'b0;
        stall    = 1'b0;
        respond(32'h5555_0013, 64'h8000_0400);
        tick();
        iresp_data_ok = 1'b0;
        exp_f = sb.pop_front();
        n_assert++;
        if (dataF !== exp_f || ireq_addr !== 64'h8000_0404) begin
            n_fail++;
            $display("FAIL b2b_after: got dataF=%h addr=%h expected dataF=%h addr=%h",
                     dataF, ireq_addr, exp_f, 64'h8000_0404);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect      = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hBAD0_0004;
        tick();
        n_assert++;
        if (ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_target: got %h expected %h", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        respond(32'h6666_0013, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        iresp_data_ok = 1'b0;
        exp_f = sb.pop_front();
        n_assert++;
        if (dataF !== exp_f || ireq_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL wrap_next: got dataF=%h addr=%h expected dataF=%h addr=0",
                     dataF, ireq_addr, exp_f);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while in DROP.
        do_reset();
        respond(32'h7777_0013, PC_RESET);
        tick();
        sb.delete();
        iresp_data_ok = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 64'h8000_0800;
        tick();
        redirect = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drop: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                     ireq_valid, ireq_addr, dataF.valid, PC_RESET);
        end
        // Reset while in HOLD.
        stall = 1'b1;
        respond(32'h8888_0013, PC_RESET);
        tick();
        sb.delete();
        iresp_data_ok = 1'b0;
        reset         = 1'b0;
        tick();
        reset = 1'b1;
        n_assert++;
        if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET || dataF.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: got valid=%b addr=%h fvalid=%b expected valid=1 addr=%h fvalid=0",
                     ireq_valid, ireq_addr, dataF.valid, PC_RESET);
        end
        stall = 1'b0;
        respond(32'h9999_0013, PC_RESET);
        tick();
        iresp_data_ok = 1'b0;
        exp_f = sb.pop_front();
        n_assert++;
        if (dataF !== exp_f) begin
            n_fail++;
            $display("FAIL rst_after: got %h expected %h", dataF, exp_f);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h0000_0000_8000_0000: the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-004 SHALL have port ireq_valid, output, 1 bit: instruction-bus request valid.
REQ-005 SHALL have port ireq_addr, output, 64 bits: instruction fetch address.
REQ-006 SHALL have port iresp_data_ok, input, 1 bit: the bus returns the instruction this cycle.
REQ-007 SHALL have port iresp_data, input, 32 bits: the instruction word; valid only while iresp_data_ok=1.
REQ-008 SHALL have port stall, input, 1 bit: hazard unit holds the F/D register.
REQ-009 SHALL have port redirect, input, 1 bit: taken branch/jump from decode.
REQ-010 SHALL have port redirect_pc, input, 64 bits: the branch target.
REQ-011 SHALL have port dataF, output, fetch_data_t {instr 32, pc 64, valid 1}: the registered F/D payload to decode.

Function
REQ-012 SHALL hold registers: pc (next fetch address), req_addr (address of the outstanding request), a one-entry hold buffer {instr, pc}, the dataF register, and FSM state {REQ, HOLD, DROP}.
REQ-013 SHALL drive ireq_valid=1 in REQ and DROP, and ireq_valid=0 in HOLD.
REQ-014 SHALL drive ireq_addr=req_addr; req_addr SHALL stay stable from request issue until the cycle iresp_data_ok=1.
REQ-015 In REQ, a new request SHALL use req_addr=pc; after iresp_data_ok the next request SHALL issue in the following cycle (1 transaction at most outstanding).
REQ-016 In REQ with iresp_data_ok=1, stall=0, redirect=0: dataF<= {iresp_data, req_addr, 1}; pc<=req_addr+4; req_addr<=req_addr+4; stay in REQ.
REQ-017 In REQ with iresp_data_ok=1, stall=1, redirect=0: the hold buffer<= {iresp_data, req_addr}; pc<=req_addr+4; dataF unchanged; go to HOLD.
REQ-018 In REQ with iresp_data_ok=0, redirect=0: if stall=0, dataF.valid<=0 (bubble); if stall=1, dataF is unchanged.
REQ-019 In HOLD with stall=0, redirect=0: dataF<= {the buffered instr and pc, 1}; req_addr<=pc; go to REQ.
REQ-020 In HOLD with stall=1, redirect=0: no change.
REQ-021 Redirect SHALL take priority over stall and over iresp_data_ok in every state.
REQ-022 On redirect, the following SHALL happen in all cases:
 - pc <= {redirect_pc[63:2], 2'b00};
 - dataF.valid <= 0;
 - the hold buffer is discarded.
REQ-023 Redirect in REQ with iresp_data_ok=0 SHALL go to DROP: the outstanding request stays driven at its old req_addr until iresp_data_ok; the response is discarded.
REQ-024 Redirect in REQ with iresp_data_ok=1 SHALL discard the response, set req_addr to the new pc value, and stay in REQ.
REQ-025 Redirect in HOLD SHALL go to REQ with req_addr = the new pc value.
REQ-026 DROP with iresp_data_ok=1 SHALL discard the data, set req_addr<=pc, and go to REQ; dataF.valid SHALL stay 0 while in DROP.
REQ-027 Redirect in DROP SHALL update pc only and stay in DROP.
REQ-028 pc+4 SHALL wrap modulo 2^64 (for example 64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-029 Latency: iresp_data_ok in cycle N with no stall SHALL make dataF valid in cycle N+1.

Reset
REQ-030 When reset=0 at a clk edge, the block SHALL set:
 - state=REQ;
 - pc=req_addr=PC_RESET;
 - dataF = {0, 0, 0};
 - the hold buffer cleared.
 Any outstanding request is abandoned without waiting for iresp_data_ok.
REQ-031 In the first cycle after reset returns to 1, ireq_valid SHALL be 1 with ireq_addr=PC_RESET.

Verification
REQ-032 Reset then respond each cycle with data 32'h00000013 (stall=0, redirect=0): ireq_addr SHALL run 80000000, 80000004, ...; dataF.pc SHALL follow one cycle later with valid=1.
REQ-033 Response for 80000004 while stall=1 for 3 cycles: ireq_valid=0 in HOLD and dataF is held; on stall release dataF={instr, 80000004, 1}, then a request for 80000008.
REQ-034 Redirect to 80000103 while the request for 80000010 is outstanding and data_ok arrives 2 cycles later:
 - ireq_addr stays 80000010 until data_ok;
 - that data is dropped;
 - the next request is 80000100;
 - dataF.valid=0 throughout.
REQ-035 Redirect and iresp_data_ok in the same cycle, also with stall=1: the response is not delivered and the next request uses the redirect target.
REQ-036 Redirect to FFFFFFFFFFFFFFFC followed by a response: the next ireq_addr SHALL be 0.
REQ-037 Assert reset=0 in DROP and in HOLD: the next cycle SHALL be state REQ with ireq_addr=PC_RESET and dataF.valid=0.
